rt_job_sched: RTL and testbench
===============================

# rt_job_sched

Job scheduler between the host Avalon-MM bus and the raytracer core. The host queues per-tile/per-frame job arguments, and the block launches them one at a time on the core's start/end handshake. It captures each job's completion status into a readback FIFO and raises a level interrupt while results are pending. It replaces direct host pulsing of the core start, so the core can run back-to-back jobs without host round-trips.

## Interface
- QDEPTH, 4: depth of job queue and done queue; power of two, 2..128
- TIMEOUT_CYC, 16777216: watchdog limit in cycles; used only with RT_JOB_TIMEOUT_EN

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- avs_address  in  1  register select: 0 = data, 1 = control/status
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_read  in  1  read strobe
- avs_readdata  out  32  registered read data
- irq  out  1  level interrupt
- start_rt  out  1  one-cycle launch pulse to the core
- job_arg  out  32  argument of the current job; held from launch until retire
- end_rt  in  1  one-cycle completion pulse from the core
- end_rtstat  in  32  core status, valid with end_rt
- busy  out  1  FSM not in IDLE

## Operation
- Write address 0: push writedata into the job queue.
  - If the queue is full, the data is dropped and sticky flag ovf is set.
- Write address 1:
  - bit0 sets irq_en.
  - bit1 = 1 clears ovf and tmo.
  - bit2 = 1 flushes the job queue; an in-flight job is unaffected.
- Read address 0: return the done queue head and pop it. If the done queue is empty, return 0 with no pop.
- Read address 1: return status.
  - [7:0] job queue count
  - [15:8] done queue count
  - [16] busy
  - [17] ovf
  - [18] tmo
  - [19] irq_en
  - all other bits 0
- FSM states:
  - IDLE → LAUNCH when the job queue is non-empty and the done queue is not full. The done-queue check is backpressure that guarantees a retire slot.
  - LAUNCH: start_rt = 1, job_arg ← queue head, pop job queue; → RUN unconditionally.
  - RUN: on end_rt, latch end_rtstat → RETIRE.
  - RETIRE: push the latched status into the done queue → IDLE.
- end_rt is ignored outside RUN.
- Simultaneous events:
  - Host push and scheduler pop of the job queue in the same cycle both take effect; count is unchanged. Push to a full queue in that cycle is accepted, because the pop frees a slot.
  - RETIRE push and host pop of the done queue in the same cycle both take effect.
  - avs_write and avs_read in the same cycle are both processed.
- irq = irq_en AND (done count ≠ 0), registered.
- Reset mid-job:
  - FSM goes to IDLE; both queues, flags and irq_en are cleared.
  - A later end_rt from the core is ignored.

## Timing
- Reset values:
  - avs_readdata = 0, irq = 0, start_rt = 0, job_arg = 0, busy = 0
  - counts = 0, ovf = tmo = irq_en = 0
- Read latency: 1 cycle. avs_readdata is valid the cycle after avs_read. A pop triggered by a read is visible in counts the following cycle.
- Launch latency:
  - Job pushed at edge N: queue non-empty in cycle N+1, state LAUNCH and start_rt = 1 in cycle N+2, RUN from cycle N+3.
  - Back-to-back jobs: the minimum spacing from one start_rt to the next is 4 cycles plus the core's runtime.
- Retire: end_rt in cycle M → RETIRE in cycle M+1 → done count increments at edge M+2 → irq = 1 in cycle M+3 (if irq_en).
- job_arg is stable from the LAUNCH cycle through RETIRE. After RETIRE it keeps its value until the next LAUNCH.
- Counts are 8 bits wide, zero-extended. Queue pointers wrap modulo QDEPTH.

## Configuration
- RT_JOB_TIMEOUT_EN defined:
  - A 32-bit counter clears on LAUNCH and increments in RUN.
  - When the counter reaches TIMEOUT_CYC - 1 without end_rt: push 0xFFFF_FFFF into the done queue, set tmo, and go to IDLE.
  - end_rt arriving in that same cycle wins; its status is retired normally.
- Without the macro: no counter, RUN waits indefinitely, status bit 18 reads 0.

## Test plan
- Reset, then read address 1 → 0x0000_0000; irq = 0; start_rt stays 0 for 20 cycles.
- Write ctrl 0x1, push 0x0000_0011; core model returns end_rt with stat 0xA5A5_0001 after 10 cycles:
  - start_rt pulses once, with job_arg = 0x11.
  - irq rises 3 cycles after end_rt.
  - Read address 0 → 0xA5A5_0001; irq drops within 2 cycles.
- Push 5 jobs with QDEPTH = 4 while the core is stalled:
  - First 4 accepted (first is launched), fifth accepted or dropped per occupancy at that cycle. A push to a full queue sets ovf = 1.
  - Ctrl write 0x2 clears ovf.
- Fill the done queue to 4 without reading: the next job is not launched (busy = 0, job count held). One read releases exactly one launch.
- Assert reset during RUN, then assert end_rt: FSM in IDLE, done count 0, irq 0, no push.
- With RT_JOB_TIMEOUT_EN and TIMEOUT_CYC = 64, launch and never answer: after 64 RUN cycles the done head is 0xFFFF_FFFF and tmo = 1. The next queued job launches normally.

Source files
------------

// File: rtl/rt_job_sched.sv
// rt_job_sched: queues host job arguments, launches them one at a time on the
// raytracer core's start/end handshake, collects completion status into a
// readback queue and raises a level interrupt while results are pending.
// Optional watchdog: define RT_JOB_TIMEOUT_EN to retire hung jobs with status
// 0xFFFF_FFFF after TIMEOUT_CYC cycles in RUN.
module rt_job_sched #(
    parameter int QDEPTH      = 4,
    parameter int TIMEOUT_CYC = 16777216
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        irq,
    output logic        start_rt,
    output logic [31:0] job_arg,
    input  logic        end_rt,
    input  logic [31:0] end_rtstat,
    output logic        busy
);

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] QD = CW'(QDEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_RETIRE} state_t;

    state_t state_reg, state_next;

    logic [31:0]   job_mem [QDEPTH];
    logic [AW-1:0] job_wr_ptr_reg, job_rd_ptr_reg;
    logic [CW-1:0] job_count_reg;

    logic [31:0]   done_mem [QDEPTH];
    logic [AW-1:0] done_wr_ptr_reg, done_rd_ptr_reg;
    logic [CW-1:0] done_count_reg;

    logic [31:0] job_arg_reg, stat_reg, readdata_reg;
    logic        irq_reg, irq_en_reg, ovf_reg;
    logic        tmo_flag, timeout_fire;

    logic wr_data, wr_ctrl, rd_data, rd_stat, flush;
    logic job_empty, job_full, done_empty, done_full, launch_ok;
    logic job_push, job_pop, done_push, done_pop;
    logic [31:0] done_push_data, status_word;

    // Bus decode and queue handshakes
    assign wr_data    = avs_write && !avs_address;
    assign wr_ctrl    = avs_write && avs_address;
    assign rd_data    = avs_read && !avs_address;
    assign rd_stat    = avs_read && avs_address;
    assign flush      = wr_ctrl && avs_writedata[2];

    assign job_empty  = (job_count_reg == '0);
    assign job_full   = (job_count_reg == QD);
    assign done_empty = (done_count_reg == '0);
    assign done_full  = (done_count_reg == QD);

    // A free done slot is required before launch so the retire never stalls.
    assign launch_ok  = !job_empty && !done_full;

    assign job_pop    = (state_reg == S_LAUNCH) && !job_empty && !flush;
    // A full queue still accepts a push when the scheduler frees a slot.
    assign job_push   = wr_data && (!job_full || job_pop);
    assign done_pop   = rd_data && !done_empty;
    assign done_push  = ((state_reg == S_RETIRE) || timeout_fire) && (!done_full || done_pop);
    assign done_push_data = timeout_fire ? 32'hFFFF_FFFF : stat_reg;

`ifdef RT_JOB_TIMEOUT_EN
    logic [31:0] timer_reg;
    logic        tmo_reg;

    // end_rt in the expiry cycle wins, so the watchdog only fires without it.
    assign timeout_fire = (state_reg == S_RUN) && !end_rt &&
                          (timer_reg == 32'(TIMEOUT_CYC - 1));
    assign tmo_flag     = tmo_reg;

    // Watchdog counter: cleared at launch, counts cycles spent in RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_reg <= '0;
        end else if (state_reg == S_LAUNCH) begin
            timer_reg <= '0;
        end else if (state_reg == S_RUN) begin
            timer_reg <= timer_reg + 32'd1;
        end
    end

    // Sticky timeout flag, cleared by host control write
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_reg <= 1'b0;
        end else begin
            if (wr_ctrl && avs_writedata[1]) tmo_reg <= 1'b0;
            if (timeout_fire)                tmo_reg <= 1'b1;
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign tmo_flag     = 1'b0;
    // The watchdog limit has no effect in this build; keep it referenced.
    if (TIMEOUT_CYC < 1) begin : g_timeout_unused
    end
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (launch_ok) state_next = S_LAUNCH;
            S_LAUNCH: state_next = S_RUN;
            S_RUN: begin
                if (end_rt)            state_next = S_RETIRE;
                else if (timeout_fire) state_next = S_IDLE;
            end
            S_RETIRE: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Job queue storage (no reset, maps to RAM)
    always_ff @(posedge clk) begin
        if (job_push) job_mem[job_wr_ptr_reg] <= avs_writedata;
    end

    // Job queue pointers and occupancy; flush drops everything queued
    always_ff @(posedge clk) begin
        if (reset) begin
            job_wr_ptr_reg <= '0;
            job_rd_ptr_reg <= '0;
            job_count_reg  <= '0;
        end else if (flush) begin
            job_rd_ptr_reg <= job_wr_ptr_reg;
            job_count_reg  <= '0;
        end else begin
            if (job_push) job_wr_ptr_reg <= job_wr_ptr_reg + AW'(1);
            if (job_pop)  job_rd_ptr_reg <= job_rd_ptr_reg + AW'(1);
            case ({job_push, job_pop})
                2'b10:   job_count_reg <= job_count_reg + CW'(1);
                2'b01:   job_count_reg <= job_count_reg - CW'(1);
                default: job_count_reg <= job_count_reg;
            endcase
        end
    end

    // Done queue storage (no reset, maps to RAM)
    always_ff @(posedge clk) begin
        if (done_push) done_mem[done_wr_ptr_reg] <= done_push_data;
    end

    // Done queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            done_wr_ptr_reg <= '0;
            done_rd_ptr_reg <= '0;
            done_count_reg  <= '0;
        end else begin
            if (done_push) done_wr_ptr_reg <= done_wr_ptr_reg + AW'(1);
            if (done_pop)  done_rd_ptr_reg <= done_rd_ptr_reg + AW'(1);
            case ({done_push, done_pop})
                2'b10:   done_count_reg <= done_count_reg + CW'(1);
                2'b01:   done_count_reg <= done_count_reg - CW'(1);
                default: done_count_reg <= done_count_reg;
            endcase
        end
    end

    // Launch argument is read from the queue head on entry to LAUNCH and held
    // until the next launch; core status is captured on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            job_arg_reg <= '0;
            stat_reg    <= '0;
        end else begin
            if (state_reg == S_IDLE && launch_ok)  job_arg_reg <= job_mem[job_rd_ptr_reg];
            if (state_reg == S_RUN && end_rt)      stat_reg    <= end_rtstat;
        end
    end

    // Status word layout seen by the host
    assign status_word = {12'd0, irq_en_reg, tmo_flag, ovf_reg, busy,
                          8'(done_count_reg), 8'(job_count_reg)};

    // Registered read data; an empty done queue reads as zero
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_reg <= '0;
        end else if (rd_data) begin
            readdata_reg <= done_empty ? 32'd0 : done_mem[done_rd_ptr_reg];
        end else if (rd_stat) begin
            readdata_reg <= status_word;
        end
    end

    // Control flags and registered interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_reg <= 1'b0;
            ovf_reg    <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            if (wr_ctrl)                     irq_en_reg <= avs_writedata[0];
            if (wr_ctrl && avs_writedata[1]) ovf_reg    <= 1'b0;
            if (wr_data && !job_push)        ovf_reg    <= 1'b1;
            irq_reg <= irq_en_reg && !done_empty;
        end
    end

    assign avs_readdata = readdata_reg;
    assign irq          = irq_reg;
    assign start_rt     = (state_reg == S_LAUNCH);
    assign job_arg      = job_arg_reg;
    assign busy         = (state_reg != S_IDLE);

endmodule

// File: tb/tb_rt_job_sched.sv
// Testbench for rt_job_sched: directed host/core stimulus, a queue-based
// reference model checked every cycle, plus literal expectations.
module tb_rt_job_sched;

    localparam int QD   = 4;
    localparam int TCYC = 64;

    localparam int P_IDLE   = 0;
    localparam int P_LAUNCH = 1;
    localparam int P_RUN    = 2;
    localparam int P_RETIRE = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        irq;
    logic        start_rt;
    logic [31:0] job_arg;
    logic        end_rt;
    logic [31:0] end_rtstat;
    logic        busy;

    rt_job_sched #(.QDEPTH(QD), .TIMEOUT_CYC(TCYC)) dut (
        .clk          (clk),
        .reset        (reset),
        .avs_address  (avs_address),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_read     (avs_read),
        .avs_readdata (avs_readdata),
        .irq          (irq),
        .start_rt     (start_rt),
        .job_arg      (job_arg),
        .end_rt       (end_rt),
        .end_rtstat   (end_rtstat),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] job_q[$];
    logic [31:0] done_q[$];
    int          m_phase = P_IDLE;
    int          m_tmr   = 0;
    logic [31:0] m_arg = '0, m_stat = '0, m_rd = '0;
    logic        m_irq = 1'b0, m_irq_en = 1'b0, m_ovf = 1'b0, m_tmo = 1'b0;

    function automatic logic [31:0] m_status();
        return {12'd0, m_irq_en, m_tmo, m_ovf, (m_phase != P_IDLE),
                8'(done_q.size()), 8'(job_q.size())};
    endfunction

    task automatic model_step();
        int          jn, dn, nxt;
        bit          dpop, sched_pop, retire, tmo_set, nirq;
        logic [31:0] rv;
        if (reset) begin
            job_q.delete(); done_q.delete();
            m_phase = P_IDLE; m_tmr = 0; m_arg = '0; m_stat = '0; m_rd = '0;
            m_irq = 0; m_irq_en = 0; m_ovf = 0; m_tmo = 0;
            return;
        end
        jn = job_q.size(); dn = done_q.size();
        nirq = m_irq_en && (dn != 0);
        dpop = 0; sched_pop = 0; retire = 0; tmo_set = 0; rv = '0; nxt = m_phase;
        if (avs_read) begin
            if (!avs_address) begin
                if (dn != 0) begin m_rd = done_q[0]; dpop = 1; end
                else m_rd = '0;
            end else begin
                m_rd = m_status();
            end
        end
        case (m_phase)
            P_IDLE: if (jn != 0 && dn < QD) begin m_arg = job_q[0]; nxt = P_LAUNCH; end
            P_LAUNCH: begin sched_pop = 1; m_tmr = 0; nxt = P_RUN; end
            P_RUN: begin
                if (end_rt) begin
                    m_stat = end_rtstat; nxt = P_RETIRE;
                end else begin
`ifdef RT_JOB_TIMEOUT_EN
                    if (m_tmr == TCYC - 1) begin
                        retire = 1; rv = 32'hFFFF_FFFF; tmo_set = 1; nxt = P_IDLE;
                    end else begin
                        m_tmr++;
                    end
`endif
                end
            end
            default: begin retire = 1; rv = m_stat; nxt = P_IDLE; end
        endcase
        if (avs_write && avs_address) begin
            m_irq_en = avs_writedata[0];
            if (avs_writedata[1]) begin m_ovf = 0; m_tmo = 0; end
            if (avs_writedata[2]) job_q.delete();
        end
        if (tmo_set) m_tmo = 1;
        if (sched_pop && job_q.size() != 0) void'(job_q.pop_front());
        if (avs_write && !avs_address) begin
            if (job_q.size() < QD) job_q.push_back(avs_writedata);
            else m_ovf = 1;
        end
        if (dpop) void'(done_q.pop_front());
        if (retire && done_q.size() < QD) done_q.push_back(rv);
        m_irq   = nirq;
        m_phase = nxt;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of every DUT output against the model
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("cyc_busy",     32'(busy),     32'(m_phase != P_IDLE));
            check("cyc_start_rt", 32'(start_rt), 32'(m_phase == P_LAUNCH));
            check("cyc_job_arg",  job_arg,       m_arg);
            check("cyc_irq",      32'(irq),      32'(m_irq));
            check("cyc_readdata", avs_readdata,  m_rd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic a, input logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_write = 1'b1; avs_writedata = d;
        @(negedge clk);
        avs_write = 1'b0;
        $display("write addr=%0d data=0x%08h", a, d);
    endtask

    task automatic bus_rd(input logic a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
        $display("read  addr=%0d data=0x%08h", a, d);
    endtask

    task automatic wait_start(input int lim, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            if (start_rt === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_start: start_rt not seen within %0d cycles", lim);
        end else begin
            $display("launch job_arg=0x%08h", job_arg);
        end
    endtask

    task automatic pulse_end(input logic [31:0] s);
        @(negedge clk);
        end_rt = 1'b1; end_rtstat = s;
        @(negedge clk);
        end_rt = 1'b0;
        $display("end_rt stat=0x%08h", s);
    endtask

    task automatic count_starts(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (start_rt === 1'b1) cnt++;
        end
    endtask

    // Hard stop so a hung run still reports
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed test sequence ----------------
    initial begin
        logic [31:0] v;
        bit          seen;
        int          n;

        reset = 1'b1; avs_address = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        avs_read = 1'b0; end_rt = 1'b0; end_rtstat = '0;
        tick(3);
        cmp_en = 1'b1;
        reset  = 1'b0;

        // Reset state
        bus_rd(1'b1, v);
        check("reset_status", v, 32'h0000_0000);
        check("reset_irq", 32'(irq), 32'd0);
        count_starts(20, n);
        check("idle_no_start", n, 0);

        // Single job with irq
        bus_wr(1'b1, 32'h1);
        bus_wr(1'b0, 32'h11);
        wait_start(40, seen);
        check("launch_arg", job_arg, 32'h11);
        count_starts(10, n);
        check("single_start", n, 0);
        end_rt = 1'b1; end_rtstat = 32'hA5A5_0001;
        @(negedge clk);
        end_rt = 1'b0;
        check("irq_m1", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_m2", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_m3", 32'(irq), 32'd1);
        bus_rd(1'b0, v);
        check("done_head", v, 32'hA5A5_0001);
        @(negedge clk);
        check("irq_drop", 32'(irq), 32'd0);

        // Stalled core: fill the job queue and overflow it
        for (int i = 0; i < 6; i++) bus_wr(1'b0, 32'h100 + 32'(i));
        bus_rd(1'b1, v);
        check("ovf_status", v, 32'h000B_0004);
        bus_wr(1'b1, 32'h2);
        bus_rd(1'b1, v);
        check("ovf_clear", v, 32'h0001_0004);

        // Fill done queue to backpressure the scheduler
        for (int i = 0; i < 4; i++) begin
            if (i > 0) wait_start(40, seen);
            tick(2);
            pulse_end(32'hD000 + 32'(i));
        end
        tick(10);
        check("bp_busy", 32'(busy), 32'd0);
        bus_rd(1'b1, v);
        check("bp_status", v, 32'h0000_0401);
        bus_rd(1'b0, v);
        check("bp_head", v, 32'hD000);
        wait_start(40, seen);
        check("bp_arg", job_arg, 32'h104);
        count_starts(10, n);
        check("bp_one_launch", n, 0);
        pulse_end(32'hD004);
        for (int i = 1; i < 5; i++) begin
            bus_rd(1'b0, v);
            check("bp_drain", v, 32'hD000 + 32'(i));
        end

        // Reset mid-job, then a stale end_rt
        bus_wr(1'b1, 32'h1);
        bus_wr(1'b0, 32'h1FF);
        wait_start(40, seen);
        tick(2);
        pulse_end(32'h1FF0);
        bus_wr(1'b0, 32'h200);
        wait_start(40, seen);
        tick(3);
        check("pre_reset_irq", 32'(irq), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("reset pulse during RUN");
        pulse_end(32'h0000_0BAD);
        tick(4);
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_irq", 32'(irq), 32'd0);
        bus_rd(1'b1, v);
        check("post_reset_status", v, 32'h0000_0000);

`ifdef RT_JOB_TIMEOUT_EN
        // Watchdog: first job never answered, second launches afterwards
        bus_wr(1'b0, 32'h77);
        bus_wr(1'b0, 32'h88);
        wait_start(40, seen);
        check("tmo_arg1", job_arg, 32'h77);
        wait_start(100, seen);
        check("tmo_arg2", job_arg, 32'h88);
        bus_rd(1'b0, v);
        check("tmo_head", v, 32'hFFFF_FFFF);
        bus_rd(1'b1, v);
        check("tmo_flag", (v >> 18) & 32'd1, 32'd1);
        pulse_end(32'h0000_0088);
        tick(5);
        bus_rd(1'b0, v);
        check("tmo_next_done", v, 32'h0000_0088);
`endif

        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
